// File: rtl/data_inf_pattern_tx.sv
// data_inf stream source: incrementing / constant / LFSR bursts of programmable length and gap.
// Registered outputs, first beat 1 cycle after start; valid/data hold through any ready stall.
module data_inf_pattern_tx #(
    parameter int DSIZE  = 8,
    parameter int LSIZE  = 16,
    parameter int GAP_EN = 1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [DSIZE-1:0] seed,
    input  logic [LSIZE-1:0] length,
    input  logic [3:0]       gap,
    input  logic             abort,
    output logic             valid,
    input  logic             ready,
    output logic [DSIZE-1:0] data,
    output logic             busy,
    output logic             done,
    output logic [LSIZE-1:0] beat_cnt
);

    function automatic logic [63:0] bit_at(input int p);
        return (p > 0) ? (64'd1 << (p - 1)) : 64'd0;
    endfunction

    function automatic logic [63:0] tp(input int a, input int b, input int c = 0,
                                       input int d = 0, input int e = 0, input int f = 0);
        return bit_at(a) | bit_at(b) | bit_at(c) | bit_at(d) | bit_at(e) | bit_at(f);
    endfunction

    // Maximal-length tap positions (1-based); bit n-1 of the mask is always set.
    function automatic logic [63:0] lfsr_taps(input int n);
        logic [63:0] m;
        m = '0;
        case (n)
            2:  m = tp(2, 1);           3:  m = tp(3, 2);          4:  m = tp(4, 3);
            5:  m = tp(5, 3);           6:  m = tp(6, 5);          7:  m = tp(7, 6);
            8:  m = tp(8, 6, 5, 4);     9:  m = tp(9, 5);          10: m = tp(10, 7);
            11: m = tp(11, 9);          12: m = tp(12, 6, 4, 1);   13: m = tp(13, 4, 3, 1);
            14: m = tp(14, 5, 3, 1);    15: m = tp(15, 14);        16: m = tp(16, 15, 13, 4);
            17: m = tp(17, 14);         18: m = tp(18, 11);        19: m = tp(19, 6, 2, 1);
            20: m = tp(20, 17);         21: m = tp(21, 19);        22: m = tp(22, 21);
            23: m = tp(23, 18);         24: m = tp(24, 23, 22, 17); 25: m = tp(25, 22);
            26: m = tp(26, 6, 2, 1);    27: m = tp(27, 5, 2, 1);   28: m = tp(28, 25);
            29: m = tp(29, 27);         30: m = tp(30, 6, 4, 1);   31: m = tp(31, 28);
            32: m = tp(32, 22, 2, 1);   33: m = tp(33, 20);        34: m = tp(34, 27, 2, 1);
            35: m = tp(35, 33);         36: m = tp(36, 25);        37: m = tp(37, 5, 4, 3, 2, 1);
            38: m = tp(38, 6, 5, 1);    39: m = tp(39, 35);        40: m = tp(40, 38, 21, 19);
            41: m = tp(41, 38);         42: m = tp(42, 41, 20, 19); 43: m = tp(43, 42, 38, 37);
            44: m = tp(44, 43, 18, 17); 45: m = tp(45, 44, 42, 41); 46: m = tp(46, 45, 26, 25);
            47: m = tp(47, 42);         48: m = tp(48, 47, 21, 20); 49: m = tp(49, 40);
            50: m = tp(50, 49, 24, 23); 51: m = tp(51, 50, 36, 35); 52: m = tp(52, 49);
            53: m = tp(53, 52, 38, 37); 54: m = tp(54, 53, 18, 17); 55: m = tp(55, 31);
            56: m = tp(56, 55, 35, 34); 57: m = tp(57, 50);        58: m = tp(58, 39);
            59: m = tp(59, 58, 38, 37); 60: m = tp(60, 59);        61: m = tp(61, 60, 46, 45);
            62: m = tp(62, 61, 6, 5);   63: m = tp(63, 62);        64: m = tp(64, 63, 61, 60);
            default: m = '0;
        endcase
        return m;
    endfunction

    localparam logic [DSIZE-1:0] TAPS = DSIZE'(lfsr_taps(DSIZE));

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_FIN} state_t;

    state_t           state, state_nxt;
    logic             valid_nxt, busy_nxt, done_nxt, abort_pend, abort_nxt;
    logic [DSIZE-1:0] data_nxt, next_dat, first_dat, seed_q, seed_nxt;
    logic [LSIZE-1:0] cnt_nxt, cnt_inc, len_q, len_nxt;
    logic [1:0]       mode_q, mode_nxt;
    logic [3:0]       gap_q, gap_nxt, gap_cnt, gap_cnt_nxt;

    assign cnt_inc   = beat_cnt + LSIZE'(1);
    assign first_dat = (mode == 2'd2 && seed == '0) ? DSIZE'(1) : seed;

    always_comb begin
        case (mode_q)
            2'd1:    next_dat = seed_q;
            2'd2:    next_dat = {1'b0, data[DSIZE-1:1]} ^ (data[0] ? TAPS : '0);
            default: next_dat = data + DSIZE'(1);
        endcase
    end

    always_comb begin
        state_nxt   = state;
        valid_nxt   = valid;
        data_nxt    = data;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        cnt_nxt     = beat_cnt;
        mode_nxt    = mode_q;
        seed_nxt    = seed_q;
        len_nxt     = len_q;
        gap_nxt     = gap_q;
        gap_cnt_nxt = gap_cnt;
        abort_nxt   = abort_pend;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    mode_nxt  = mode;
                    seed_nxt  = seed;
                    len_nxt   = length;
                    gap_nxt   = (GAP_EN != 0) ? gap : 4'd0;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    abort_nxt = 1'b0;
                    if (length == '0) begin
                        state_nxt = ST_FIN;
                    end else begin
                        state_nxt = ST_SEND;
                        valid_nxt = 1'b1;
                        data_nxt  = first_dat;
                    end
                end
            end
            ST_SEND: begin
                if (ready) begin
                    cnt_nxt = cnt_inc;
                    // An abort seen during a stall still lets the pending beat complete.
                    if (cnt_inc == len_q || abort || abort_pend) begin
                        valid_nxt = 1'b0;
                        state_nxt = ST_FIN;
                    end else if (gap_q != 4'd0) begin
                        valid_nxt   = 1'b0;
                        gap_cnt_nxt = gap_q;
                        state_nxt   = ST_GAP;
                    end else begin
                        data_nxt = next_dat;
                    end
                end else if (abort) begin
                    abort_nxt = 1'b1;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_nxt = ST_FIN;
                end else if (gap_cnt == 4'd1) begin
                    state_nxt = ST_SEND;
                    valid_nxt = 1'b1;
                    data_nxt  = next_dat;
                end else begin
                    gap_cnt_nxt = gap_cnt - 4'd1;
                end
            end
            default: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= ST_IDLE;
            valid      <= 1'b0;
            data       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            beat_cnt   <= '0;
            mode_q     <= 2'd0;
            seed_q     <= '0;
            len_q      <= '0;
            gap_q      <= 4'd0;
            gap_cnt    <= 4'd0;
            abort_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            valid      <= valid_nxt;
            data       <= data_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            beat_cnt   <= cnt_nxt;
            mode_q     <= mode_nxt;
            seed_q     <= seed_nxt;
            len_q      <= len_nxt;
            gap_q      <= gap_nxt;
            gap_cnt    <= gap_cnt_nxt;
            abort_pend <= abort_nxt;
        end
    end

endmodule

// File: tb/tb_data_inf_pattern_tx.sv
// Bench for data_inf_pattern_tx: queue-based data model plus directed timing checks.
module tb_data_inf_pattern_tx;

    localparam int DSIZE = 8;
    localparam int LSIZE = 16;

    logic             clock = 1'b0;
    logic             rst, start, abort, ready;
    logic [1:0]       mode;
    logic [DSIZE-1:0] seed, data;
    logic [LSIZE-1:0] length, beat_cnt;
    logic [3:0]       gap;
    logic             valid, busy, done;

    data_inf_pattern_tx #(.DSIZE(DSIZE), .LSIZE(LSIZE), .GAP_EN(1)) dut (
        .clock(clock), .rst(rst), .start(start), .mode(mode), .seed(seed),
        .length(length), .gap(gap), .abort(abort), .valid(valid), .ready(ready),
        .data(data), .busy(busy), .done(done), .beat_cnt(beat_cnt)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_pass = 0, cyc = 0;
    int got_base = 0, vld_base = 0, stall_base = 0, start_cyc = 0, done_at = -1;
    int vld_cycles = 0, stall_cycles = 0;
    logic [DSIZE-1:0] exp_q[$];
    logic [DSIZE-1:0] got_dat[$];
    int               got_cyc[$];
    logic [DSIZE-1:0] exp_v, data_prev = '0;
    logic             stall_prev = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endfunction

    function automatic logic [DSIZE-1:0] model_next(input logic [1:0] m, input logic [DSIZE-1:0] v,
                                                    input logic [DSIZE-1:0] s);
        case (m)
            2'd1:    return s;
            2'd2:    return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
            default: return v + 8'd1;
        endcase
    endfunction

    function automatic void build_exp(input logic [1:0] m, input logic [DSIZE-1:0] s, input int n);
        logic [DSIZE-1:0] v;
        v = (m == 2'd2 && s == 8'd0) ? 8'd1 : s;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(v);
            v = model_next(m, v, s);
        end
    endfunction

    function automatic logic [63:0] dat_at(input int i);
        return (i < got_dat.size()) ? 64'(got_dat[i]) : 'x;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < got_cyc.size()) ? got_cyc[i] : -1000;
    endfunction

    // Per-cycle checker: every transfer against the model, plus stall stability.
    always @(negedge clock) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid_held", valid, 1);
                chk("stall_data_held", data, data_prev);
            end
            if (valid) vld_cycles++;
            if (valid && !busy) chk("busy_during_valid", busy, 1);
            if (valid && !ready) stall_cycles++;
            if (valid && ready) begin
                if (exp_q.size() > 0) exp_v = exp_q.pop_front();
                else exp_v = 'x;
                chk("xfer_data", data, exp_v);
                got_dat.push_back(data);
                got_cyc.push_back(cyc);
            end
            stall_prev = valid && !ready;
            data_prev  = data;
        end
    end

    task automatic launch(input logic [1:0] m, input logic [DSIZE-1:0] s,
                          input logic [LSIZE-1:0] n, input logic [3:0] g);
        @(posedge clock); #1;
        start = 1'b1; mode = m; seed = s; length = n; gap = g;
        build_exp(m, s, int'(n));
        start_cyc  = cyc;
        got_base   = got_dat.size();
        vld_base   = vld_cycles;
        stall_base = stall_cycles;
        @(posedge clock); #1;
        start = 1'b0; mode = ~m; seed = ~s; length = '1; gap = 4'hF;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen;
        seen    = 1'b0;
        done_at = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (done) begin
                seen    = 1'b1;
                done_at = cyc;
            end
        end
        chk({name, "_done_seen"}, seen, 1);
        if (seen) begin
            chk({name, "_beat_cnt_vs_xfers"}, beat_cnt, got_dat.size() - got_base);
            chk({name, "_busy_low_at_done"}, busy, 0);
            @(negedge clock);
            chk({name, "_done_one_cycle"}, done, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b;
        rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1;
        mode = 2'd0; seed = '0; length = '0; gap = 4'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        @(posedge clock); #1;
        rst = 1'b0;

        // Incrementing burst wrapping through 0xFF, ready high.
        launch(2'd0, 8'hFE, 16'd4, 4'd0);
        b = got_base;
        wait_done(40, "inc");
        chk("inc_d0", dat_at(b), 8'hFE);
        chk("inc_d1", dat_at(b + 1), 8'hFF);
        chk("inc_d2", dat_at(b + 2), 8'h00);
        chk("inc_d3", dat_at(b + 3), 8'h01);
        chk("inc_first_beat_cycle", cyc_at(b) - start_cyc, 1);
        chk("inc_back_to_back", cyc_at(b + 3) - cyc_at(b), 3);
        chk("inc_done_cycle", done_at - start_cyc, 6);
        chk("inc_beat_cnt", beat_cnt, 4);

        // Constant burst with a 3-cycle stall on the second beat.
        launch(2'd1, 8'h5A, 16'd3, 4'd0);
        b = got_base;
        @(posedge clock); #1; ready = 1'b0;
        repeat (3) @(posedge clock);
        #1; ready = 1'b1;
        wait_done(40, "stall");
        chk("stall_cycles", stall_cycles - stall_base, 3);
        chk("stall_xfers", got_dat.size() - b, 3);
        chk("stall_beat2_data", dat_at(b + 1), 8'h5A);
        chk("stall_beat2_spacing", cyc_at(b + 1) - cyc_at(b), 4);

        // Two idle cycles after each non-final beat.
        launch(2'd0, 8'h10, 16'd3, 4'd2);
        b = got_base;
        wait_done(40, "gap");
        chk("gap_spacing1", cyc_at(b + 1) - cyc_at(b), 3);
        chk("gap_spacing2", cyc_at(b + 2) - cyc_at(b + 1), 3);
        chk("gap_done_after_first", done_at - cyc_at(b), 8);
        chk("gap_valid_cycles", vld_cycles - vld_base, 3);

        // Zero-length burst.
        launch(2'd0, 8'h33, 16'd0, 4'd0);
        wait_done(20, "len0");
        chk("len0_done_cycle", done_at - start_cyc, 2);
        chk("len0_no_valid", vld_cycles - vld_base, 0);
        chk("len0_beat_cnt", beat_cnt, 0);

        // Abort during a stall; a start while busy must not re-latch anything.
        launch(2'd0, 8'h20, 16'd10, 4'd0);
        b = got_base;
        @(posedge clock); #1;
        @(posedge clock); #1; ready = 1'b0;
        @(posedge clock); #1;
        abort = 1'b1; start = 1'b1; mode = 2'd1; seed = 8'h99; length = 16'd5;
        @(posedge clock); #1;
        abort = 1'b0; start = 1'b0;
        @(posedge clock);
        @(posedge clock); #1;
        chk("abort_busy_in_stall", busy, 1);
        ready = 1'b1;
        wait_done(40, "abort_stall");
        exp_q.delete();
        chk("abort_stall_xfers", got_dat.size() - b, 3);
        chk("abort_stall_last_data", dat_at(b + 2), 8'h22);
        chk("abort_stall_beat_cnt", beat_cnt, 3);
        chk("abort_stall_done_cycle", done_at - cyc_at(b + 2), 2);
        repeat (3) @(negedge clock);
        chk("abort_stall_valid_cycles", vld_cycles - vld_base, 7);
        chk("abort_stall_stalls", stall_cycles - stall_base, 4);

        // Abort while in the inter-beat gap.
        launch(2'd0, 8'h00, 16'd5, 4'd3);
        @(posedge clock); #1; abort = 1'b1;
        @(posedge clock); #1; abort = 1'b0;
        wait_done(20, "abort_gap");
        exp_q.delete();
        chk("abort_gap_done_cycle", done_at - start_cyc, 4);
        chk("abort_gap_beat_cnt", beat_cnt, 1);

        // LFSR with zero seed.
        launch(2'd2, 8'h00, 16'd6, 4'd0);
        b = got_base;
        wait_done(40, "lfsr");
        chk("lfsr_d0", dat_at(b), 8'h01);
        chk("lfsr_d1", dat_at(b + 1), 8'hB8);
        chk("lfsr_d2", dat_at(b + 2), 8'h5C);
        chk("lfsr_d3", dat_at(b + 3), 8'h2E);
        chk("lfsr_beat_cnt", beat_cnt, 6);

        // Reset in the middle of a burst, then a fresh burst.
        launch(2'd2, 8'h33, 16'd20, 4'd0);
        b = got_base;
        @(posedge clock); #1;
        @(posedge clock); #1; rst = 1'b1;
        @(posedge clock); #1; rst = 1'b0;
        exp_q.delete();
        @(negedge clock);
        chk("midrst_valid", valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_beat_cnt", beat_cnt, 0);
        chk("midrst_xfers_before", got_dat.size() - b, 2);
        launch(2'd0, 8'h40, 16'd2, 4'd1);
        b = got_base;
        wait_done(40, "after_rst");
        chk("after_rst_d1", dat_at(b + 1), 8'h41);
        chk("after_rst_spacing", cyc_at(b + 1) - cyc_at(b), 2);
        chk("after_rst_beat_cnt", beat_cnt, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/data_inf_pattern_tx.md
Name: data_inf_pattern_tx

Overview:
- Transmitter (producer) end of the data_inf valid/ready/data stream.
- Generates a programmable-length burst of test data (incrementing, constant or LFSR) on one data_inf stream and honours downstream back-pressure.
- Used in hdl_class test benches and bring-up builds as a stimulus source, paired with existing data_inf consumers.

Parameters:
- DSIZE, 8, data width of the stream in bits (2..64).
- LSIZE, 16, width of the burst length and beat counters.
- GAP_EN, 1, 1 enables the programmable idle-gap insertion between beats; 0 ties gap to zero.

Ports:
- clock  in  1  stream clock (the codebase's dclk domain); single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; launches a burst when idle.
- mode  in  2  0 = incrementing, 1 = constant, 2 = LFSR, 3 = reserved (treated as incrementing).
- seed  in  DSIZE  first data value / LFSR seed; constant value in mode 1.
- length  in  LSIZE  beats in burst; 0 means no beats (done only).
- gap  in  4  idle cycles inserted after each accepted beat (ignored when GAP_EN = 0).
- abort  in  1  terminates the burst at the next safe point.
- valid  out  1  data_inf valid.
- ready  in  1  data_inf ready from the consumer.
- data  out  DSIZE  data_inf data.
- busy  out  1  high from start acceptance until done.
- done  out  1  single-cycle pulse at burst end.
- beat_cnt  out  LSIZE  beats accepted in the current or last burst.

Behaviour:
- Reset (sync, rst = 1 at a clock edge):
  - valid = 0, data = 0, busy = 0, done = 0, beat_cnt = 0.
  - FSM returns to IDLE.
  - Takes effect mid-burst too; the in-flight beat is dropped without a handshake.
- Handshake:
  - A beat transfers on a clock edge where valid && ready.
  - Once valid is asserted, data and valid hold stable until transfer, except on reset.
  - valid never depends combinationally on ready.
- FSM:
  - IDLE: start = 1 latches mode, seed, length and gap; beat_cnt <= 0; busy <= 1.
    - If length == 0, go to FIN.
    - Otherwise go to SEND with valid <= 1 and data <= seed on the same edge (first beat visible 1 cycle after start).
  - SEND, valid high: on transfer, beat_cnt++.
    - If beat_cnt + 1 == length, valid <= 0 and go to FIN.
    - Else if the latched gap != 0, valid <= 0, load the gap counter and go to GAP.
    - Else present the next data value with valid held high (back-to-back beats allowed).
  - GAP: count down the latched gap; valid = 0. When the counter reaches 1, go to SEND with the next data value and valid <= 1.
  - FIN: done <= 1 for one cycle, busy <= 0, go to IDLE. beat_cnt holds until the next start.
- Next data value:
  - Incrementing: data + 1, modulo 2^DSIZE (wraps, e.g. 0xFF -> 0x00 at DSIZE = 8).
  - Constant: seed.
  - LFSR: Galois right-shift with tap mask 0xB8 for DSIZE = 8; other widths use a fixed maximal polynomial table.
  - A zero seed in LFSR mode is replaced by 1.
- start while busy is ignored (no re-latch, no error).
- abort:
  - In GAP or IDLE it acts immediately: go to FIN, or no effect in IDLE.
  - In SEND with valid high, the current beat completes first. The next edge with valid && ready counts the beat, then goes to FIN.
  - abort together with transfer on the same edge counts that beat and ends the burst.
- Simultaneous start and abort in IDLE: start wins and abort is ignored.
- length == 2^LSIZE - 1 is supported; the counter must not overflow.
- The ready pattern is unconstrained, including ready stuck low forever; the block waits indefinitely.

Test Plan:
1. Incrementing, ready tied high: mode = 0, seed = 0xFE, length = 4, gap = 0 -> data 0xFE, 0xFF, 0x00, 0x01 on 4 consecutive cycles; done pulses 1 cycle after the last transfer; beat_cnt = 4.
2. Back-pressure: ready low for 3 cycles on beat 2 of a length-3 constant burst with seed = 0x5A -> valid and data stay stable at 0x5A during the stall; exactly 3 transfers occur.
3. Gap insertion: gap = 2, length = 3, ready high -> each beat followed by exactly 2 idle cycles; total 7 cycles from first valid to FIN.
4. length = 0 and start -> no valid asserted; done pulse 2 cycles after start; beat_cnt = 0.
5. Abort during a stall in SEND of a length-10 burst -> after ready rises, one more transfer then done; beat_cnt equals transfers seen; start while busy is ignored.
6. LFSR with seed = 0 at DSIZE = 8 -> first data 0x01, then the tap-0xB8 sequence. Reset asserted mid-burst -> valid, busy and done are 0 the next cycle, and a new start works normally.
